// File: rtl/buck_pwm_gen.sv
// buck_pwm_gen: power-stage PWM generator for the buck control loop.
// Takes the compensator's duty word, double-buffers it so the on-time only
// changes at period boundaries, drives complementary high/low-side gates with
// dead-time, and fires a mid-on-time ADC trigger for average-value sampling.
// Optional feature: define PWM_FAULT_EN to add the fault_in gate-kill input
// (two-flop synchronised) and the sticky fault_latched status output.

module buck_pwm_gen #(
    parameter int CNT_WIDTH = 10,
    parameter int DEADTIME  = 8,
    parameter int DUTY_MAX  = 1000,
    parameter int DUTY_MIN  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] duty_in,
    input  logic                 duty_valid,
    output logic                 pwm_hs,
    output logic                 pwm_ls,
    output logic                 period_start,
    output logic                 adc_trig,
    output logic [CNT_WIDTH-1:0] duty_active
`ifdef PWM_FAULT_EN
    ,
    input  logic                 fault_in,
    output logic                 fault_latched
`endif
);

    localparam int                   DT_W       = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DT_W-1:0]      DT_LAST    = DT_W'(DEADTIME - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] DUTY_MAX_C = CNT_WIDTH'(DUTY_MAX);
    localparam logic [CNT_WIDTH-1:0] DUTY_MIN_C = CNT_WIDTH'(DUTY_MIN);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_DT_RISE,
        ST_HS_ON,
        ST_DT_FALL,
        ST_LS_ON
    } state_t;

    // Saturate over-range requests and skip pulses too narrow to be useful.
    function automatic logic [CNT_WIDTH-1:0] clamp_duty(input logic [CNT_WIDTH-1:0] d);
        if (d > DUTY_MAX_C) begin
            return DUTY_MAX_C;
        end else if ((d != '0) && (d < DUTY_MIN_C)) begin
            return '0;
        end else begin
            return d;
        end
    endfunction

    state_t                 state_q, state_d;
    logic [DT_W-1:0]        dt_q, dt_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   duty_shadow_q, duty_shadow_d;
    logic [CNT_WIDTH-1:0]   duty_active_q, duty_active_d;
    logic                   enable_q, enable_d;
    logic                   pwm_hs_q, pwm_hs_d;
    logic                   pwm_ls_q, pwm_ls_d;
    logic                   period_start_q, period_start_d;
    logic                   adc_trig_q, adc_trig_d;

    logic [CNT_WIDTH-1:0]   duty_clamped;
    logic [CNT_WIDTH-1:0]   load_value;
    logic [CNT_WIDTH-1:0]   duty_now;
    logic                   load_now;
    logic                   raw;
    logic                   gate_kill;

`ifdef PWM_FAULT_EN
    logic fault_meta_q, fault_meta_d;
    logic fault_sync_q, fault_sync_d;
    logic fault_latched_q, fault_latched_d;

    // Synchronise the fault request and hold the sticky status until the loop is disabled.
    always_comb begin
        fault_meta_d    = fault_in;
        fault_sync_d    = fault_meta_q;
        fault_latched_d = fault_latched_q;
        if (fault_sync_q) begin
            fault_latched_d = 1'b1;
        end else if (!enable) begin
            fault_latched_d = 1'b0;
        end
    end

    // Fault synchroniser and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_meta_q    <= 1'b0;
            fault_sync_q    <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            fault_meta_q    <= fault_meta_d;
            fault_sync_q    <= fault_sync_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    assign fault_latched = fault_latched_q;
`endif

    // Conditions that force the gate FSM back to OFF.
    always_comb begin
        gate_kill = !enable;
`ifdef PWM_FAULT_EN
        gate_kill = gate_kill || fault_sync_q || fault_latched_q;
`endif
    end

    // Carrier, duty double-buffer, raw compare and sampling pulses.
    // In a load cycle the compare already uses the incoming duty so the first
    // cycle after enable rises agrees with the rest of that period.
    always_comb begin
        duty_clamped   = clamp_duty(duty_in);
        load_now       = enable && (!enable_q || (cnt_q == CNT_LAST));
        load_value     = duty_valid ? duty_clamped : duty_shadow_q;
        duty_now       = load_now ? load_value : duty_active_q;
        raw            = enable && (cnt_q < duty_now);

        cnt_d          = enable ? cnt_q + 1'b1 : '0;
        duty_shadow_d  = duty_valid ? duty_clamped : duty_shadow_q;
        duty_active_d  = duty_now;
        enable_d       = enable;
        period_start_d = enable && (cnt_q == '0);
        adc_trig_d     = enable && (cnt_q == (duty_now >> 1));
    end

    // Dead-time FSM: both gates stay low for DEADTIME cycles at every handover.
    always_comb begin
        state_d = state_q;
        dt_d    = dt_q;
        if (gate_kill) begin
            state_d = ST_OFF;
            dt_d    = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = raw ? ST_DT_RISE : ST_DT_FALL;
                    dt_d    = '0;
                end
                ST_DT_RISE: begin
                    if (!raw) begin
                        state_d = ST_LS_ON;
                        dt_d    = '0;
                    end else if (dt_q == DT_LAST) begin
                        state_d = ST_HS_ON;
                        dt_d    = '0;
                    end else begin
                        dt_d = dt_q + 1'b1;
                    end
                end
                ST_HS_ON: begin
                    if (!raw) begin
                        state_d = ST_DT_FALL;
                        dt_d    = '0;
                    end
                end
                ST_DT_FALL: begin
                    if (raw) begin
                        state_d = ST_HS_ON;
                        dt_d    = '0;
                    end else if (dt_q == DT_LAST) begin
                        state_d = ST_LS_ON;
                        dt_d    = '0;
                    end else begin
                        dt_d = dt_q + 1'b1;
                    end
                end
                ST_LS_ON: begin
                    if (raw) begin
                        state_d = ST_DT_RISE;
                        dt_d    = '0;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    dt_d    = '0;
                end
            endcase
        end
        pwm_hs_d = (state_d == ST_HS_ON);
        pwm_ls_d = (state_d == ST_LS_ON);
    end

    // All state and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_OFF;
            dt_q           <= '0;
            cnt_q          <= '0;
            duty_shadow_q  <= '0;
            duty_active_q  <= '0;
            enable_q       <= 1'b0;
            pwm_hs_q       <= 1'b0;
            pwm_ls_q       <= 1'b0;
            period_start_q <= 1'b0;
            adc_trig_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            dt_q           <= dt_d;
            cnt_q          <= cnt_d;
            duty_shadow_q  <= duty_shadow_d;
            duty_active_q  <= duty_active_d;
            enable_q       <= enable_d;
            pwm_hs_q       <= pwm_hs_d;
            pwm_ls_q       <= pwm_ls_d;
            period_start_q <= period_start_d;
            adc_trig_q     <= adc_trig_d;
        end
    end

    assign pwm_hs       = pwm_hs_q;
    assign pwm_ls       = pwm_ls_q;
    assign period_start = period_start_q;
    assign adc_trig     = adc_trig_q;
    assign duty_active  = duty_active_q;

endmodule
